// File: rtl/twi_pkg.sv
// twi_pkg: shared definitions for the TWI bus framer.
//   twi_state_t     - framer state (IDLE, DATA, ACK)
//   TWI_WIDTH       - default data bits per byte
//   TWI_SYNC_STAGES - default synchronizer depth (must be >= 2)
package twi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        ACK  = 2'd2
    } twi_state_t;

    localparam int TWI_WIDTH       = 8;
    localparam int TWI_SYNC_STAGES = 2;

endpackage

// File: rtl/twi_sync_edge.sv
// twi_sync_edge: brings one raw asynchronous TWI line into the clk domain
// and provides a one-cycle history for edge detection.
//   clk, reset - system clock, synchronous active-high reset
//   d_in       - raw asynchronous line
//   level      - synchronized level (last synchronizer stage)
//   prev       - level delayed by one clk
//   rise, fall - level/prev edge flags (combinational)
// All flops reset to 1 so an idle (high) bus produces no edge after reset.
module twi_sync_edge
    import twi_pkg::*;
#(
    parameter int SYNC_STAGES = TWI_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic d_in,
    output logic level,
    output logic prev,
    output logic rise,
    output logic fall
);

    logic r_sync [SYNC_STAGES];
    logic r_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync[0] <= 1'b1;
        end else begin
            r_sync[0] <= d_in;
        end
    end

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_sync[gi] <= 1'b1;
                end else begin
                    r_sync[gi] <= r_sync[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev <= 1'b1;
        end else begin
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign prev  = r_prev;
    assign rise  = ~r_prev &  r_sync[SYNC_STAGES-1];
    assign fall  =  r_prev & ~r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/twi_bus_framer.sv
// twi_bus_framer: frames a TWI (I2C) bus into per-bit strobes, byte/ACK
// markers and START/STOP pulses for a downstream shifter.
//   clk, reset        - system clock, synchronous active-high reset
//   scl_in, sda_in    - raw asynchronous bus lines
//   bit_valid/bit_out - one-cycle strobe + sampled data bit
//   byte_done         - pulse with the WIDTH-th bit of a byte
//   ack_valid/ack_n   - strobe + SDA level in the ACK slot
//   first_byte        - high from START until the first ACK slot
//   start_det/stop_det- START (incl. repeated) / STOP pulses
//   busy              - framer not idle
module twi_bus_framer
    import twi_pkg::*;
#(
    parameter int WIDTH       = TWI_WIDTH,
    parameter int SYNC_STAGES = TWI_SYNC_STAGES
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_in,
    input  logic sda_in,
    output logic bit_valid,
    output logic bit_out,
    output logic byte_done,
    output logic ack_valid,
    output logic ack_n,
    output logic first_byte,
    output logic start_det,
    output logic stop_det,
    output logic busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic w_scl_lvl, w_scl_prev, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_prev, w_sda_rise, w_sda_fall;

    twi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (clk),
        .reset (reset),
        .d_in  (scl_in),
        .level (w_scl_lvl),
        .prev  (w_scl_prev),
        .rise  (w_scl_rise),
        .fall  (w_scl_fall)
    );

    twi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (clk),
        .reset (reset),
        .d_in  (sda_in),
        .level (w_sda_lvl),
        .prev  (w_sda_prev),
        .rise  (w_sda_rise),
        .fall  (w_sda_fall)
    );

    // SCL fall and raw SDA history are not needed for framing.
    logic w_unused;
    assign w_unused = w_scl_fall ^ w_sda_prev;

    // START/STOP only qualify with SCL high in both cycles, so an SDA change
    // coincident with an SCL edge is never taken as a bus condition.
    logic w_scl_held, w_start, w_stop;
    assign w_scl_held = w_scl_prev & w_scl_lvl;
    assign w_start    = w_scl_held & w_sda_fall;
    assign w_stop     = w_scl_held & w_sda_rise;

    twi_state_t      r_state, w_state_next;
    logic [CW-1:0]   r_bit_cnt, w_bit_cnt_next;
    logic            w_first_next, w_bit_out_next, w_ack_n_next;
    logic            w_bit_valid_next, w_byte_done_next, w_ack_valid_next;
    logic            w_start_next, w_stop_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_bit_cnt  <= '0;
            first_byte <= 1'b0;
            bit_out    <= 1'b0;
            ack_n      <= 1'b0;
            bit_valid  <= 1'b0;
            byte_done  <= 1'b0;
            ack_valid  <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_cnt_next;
            first_byte <= w_first_next;
            bit_out    <= w_bit_out_next;
            ack_n      <= w_ack_n_next;
            bit_valid  <= w_bit_valid_next;
            byte_done  <= w_byte_done_next;
            ack_valid  <= w_ack_valid_next;
            start_det  <= w_start_next;
            stop_det   <= w_stop_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_bit_cnt_next   = r_bit_cnt;
        w_first_next     = first_byte;
        w_bit_out_next   = bit_out;
        w_ack_n_next     = ack_n;
        w_bit_valid_next = 1'b0;
        w_byte_done_next = 1'b0;
        w_ack_valid_next = 1'b0;
        w_start_next     = 1'b0;
        w_stop_next      = 1'b0;

        if (w_stop) begin
            w_stop_next    = 1'b1;
            w_bit_cnt_next = '0;
            w_first_next   = 1'b0;
            w_state_next   = IDLE;
        end else if (w_start) begin
            // Also covers repeated START: any partial byte is dropped.
            w_start_next   = 1'b1;
            w_bit_cnt_next = '0;
            w_first_next   = 1'b1;
            w_state_next   = DATA;
        end else if (w_scl_rise) begin
            case (r_state)
                DATA: begin
                    w_bit_valid_next = 1'b1;
                    w_bit_out_next   = w_sda_lvl;
                    if (r_bit_cnt == LAST_BIT) begin
                        w_byte_done_next = 1'b1;
                        w_bit_cnt_next   = '0;
                        w_state_next     = ACK;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 1'b1;
                    end
                end
                ACK: begin
                    w_ack_valid_next = 1'b1;
                    w_ack_n_next     = w_sda_lvl;
                    w_first_next     = 1'b0;
                    w_state_next     = DATA;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_twi_bus_framer.sv
module tb_twi_bus_framer;

    localparam int K_BIT = 0, K_ACK = 1, K_START = 2, K_STOP = 3, K_BAD = 4;

    typedef struct {
        int   kind;
        logic val;
        logic done;
        logic first;
    } ev_t;

    typedef struct {
        logic       restart;
        logic [7:0] data;
        logic       ack_lvl;
        logic       stop;
        logic       exp_first;
    } vec_t;

    logic clk = 1'b0;
    logic reset, scl_in, sda_in;
    logic bit_valid, bit_out, byte_done, ack_valid, ack_n;
    logic first_byte, start_det, stop_det, busy;

    int n_run  = 0;
    int n_fail = 0;

    ev_t exp_q[$];
    ev_t mon_a, mon_e;

    // bench model of the framer's protocol state
    int   m_state = 0;   // 0 idle, 1 data, 2 ack
    int   m_cnt   = 0;
    logic m_first = 1'b0;

    always #5 clk = ~clk;

    twi_bus_framer #(.WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .bit_valid  (bit_valid),
        .bit_out    (bit_out),
        .byte_done  (byte_done),
        .ack_valid  (ack_valid),
        .ack_n      (ack_n),
        .first_byte (first_byte),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .busy       (busy)
    );

    // Scoreboard: every strobe cycle must match the next expected event.
    always @(negedge clk) begin
        if (!reset && (bit_valid || byte_done || ack_valid || start_det || stop_det)) begin
            mon_a.val = 1'b0; mon_a.done = 1'b0; mon_a.first = 1'b0;
            if (bit_valid) begin
                mon_a.kind = K_BIT; mon_a.val = bit_out;
                mon_a.done = byte_done; mon_a.first = first_byte;
            end else if (byte_done) begin
                mon_a.kind = K_BAD;
            end else if (ack_valid) begin
                mon_a.kind = K_ACK; mon_a.val = ack_n;
            end else if (start_det) begin
                mon_a.kind = K_START;
            end else begin
                mon_a.kind = K_STOP;
            end
            n_run++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL event: got unexpected kind=%0d val=%b done=%b first=%b at %0t",
                         mon_a.kind, mon_a.val, mon_a.done, mon_a.first, $time);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_a.kind != mon_e.kind ||
                    (mon_e.kind == K_BIT && (mon_a.val !== mon_e.val || mon_a.done !== mon_e.done ||
                                             mon_a.first !== mon_e.first)) ||
                    (mon_e.kind == K_ACK && mon_a.val !== mon_e.val)) begin
                    n_fail++;
                    $display("FAIL event: got kind=%0d val=%b done=%b first=%b, expected kind=%0d val=%b done=%b first=%b at %0t",
                             mon_a.kind, mon_a.val, mon_a.done, mon_a.first,
                             mon_e.kind, mon_e.val, mon_e.done, mon_e.first, $time);
                end else begin
                    $display("[TB] event kind=%0d val=%b done=%b first=%b ok", mon_a.kind, mon_a.val,
                             mon_a.done, mon_a.first);
                end
            end
        end
    end

    task automatic push(input int kind, input logic val, input logic done, input logic first);
        ev_t e;
        e.kind = kind; e.val = val; e.done = done; e.first = first;
        exp_q.push_back(e);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic wait_ph();
        repeat (4) @(negedge clk);
    endtask

    task automatic drain(input string name);
        repeat (12) @(negedge clk);
        n_run++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s: got %0d missing events expected 0", name, exp_q.size());
            exp_q.delete();
        end
        $display("[TB] %s drained", name);
    endtask

    // expected effect of one SCL rise with SDA=v
    task automatic model_rise(input logic v);
        if (m_state == 1) begin
            push(K_BIT, v, (m_cnt == 7), m_first);
            if (m_cnt == 7) begin m_cnt = 0; m_state = 2; end
            else m_cnt++;
        end else if (m_state == 2) begin
            push(K_ACK, v, 1'b0, 1'b0);
            m_first = 1'b0;
            m_state = 1;
        end
    endtask

    task automatic clock_bit(input logic v);
        scl_in = 1'b0;
        sda_in = v; wait_ph();
        model_rise(v);
        scl_in = 1'b1; wait_ph();
        scl_in = 1'b0; wait_ph();
    endtask

    task automatic drv_start();
        if (!scl_in) begin
            sda_in = 1'b1; wait_ph();
            model_rise(1'b1);
            scl_in = 1'b1; wait_ph();
        end
        push(K_START, 1'b0, 1'b0, 1'b0);
        m_state = 1; m_cnt = 0; m_first = 1'b1;
        sda_in = 1'b0; wait_ph();
        scl_in = 1'b0; wait_ph();
    endtask

    task automatic drv_stop();
        if (scl_in) begin
            scl_in = 1'b0; wait_ph();
        end
        sda_in = 1'b0; wait_ph();
        model_rise(1'b0);
        scl_in = 1'b1; wait_ph();
        push(K_STOP, 1'b0, 1'b0, 1'b0);
        m_state = 0; m_cnt = 0; m_first = 1'b0;
        sda_in = 1'b1; wait_ph();
    endtask

    task automatic scl_pulse();
        scl_in = 1'b0; wait_ph();
        model_rise(sda_in);
        scl_in = 1'b1; wait_ph();
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{1'b1, 8'h50, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 8'h3C, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 8'h81, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1};

        reset = 1'b1; scl_in = 1'b1; sda_in = 1'b1;
        repeat (5) @(negedge clk);
        check1("rst_bit_valid", bit_valid, 1'b0);
        check1("rst_byte_done", byte_done, 1'b0);
        check1("rst_ack_valid", ack_valid, 1'b0);
        check1("rst_start_det", start_det, 1'b0);
        check1("rst_stop_det", stop_det, 1'b0);
        check1("rst_first_byte", first_byte, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_bit_out", bit_out, 1'b0);
        check1("rst_ack_n", ack_n, 1'b0);
        reset = 1'b0;
        drain("post_reset_quiet");

        // table of byte transactions
        for (int v = 0; v < 6; v++) begin
            if (vecs[v].restart) begin
                drv_start();
                check1("busy_after_start", busy, 1'b1);
            end
            for (int b = 7; b >= 0; b--) clock_bit(vecs[v].data[b]);
            check1("first_byte_in_byte", first_byte, vecs[v].exp_first);
            clock_bit(vecs[v].ack_lvl);
            check1("first_byte_after_ack", first_byte, 1'b0);
            check1("busy_after_ack", busy, 1'b1);
            if (vecs[v].stop) begin
                drv_stop();
                drain("vector");
                check1("busy_after_stop", busy, 1'b0);
            end
            $display("[TB] vector %0d data=%h ack=%b done", v, vecs[v].data, vecs[v].ack_lvl);
        end

        // partial byte then repeated START, then a full byte
        drv_start();
        for (int b = 0; b < 5; b++) clock_bit(b[0]);
        drv_start();
        check1("first_byte_restart", first_byte, 1'b1);
        for (int b = 7; b >= 0; b--) clock_bit(vecs[3].data[b]);
        clock_bit(1'b0);
        drv_stop();
        drain("repeated_start");

        // partial byte then STOP, then stray SCL pulses
        drv_start();
        for (int b = 0; b < 3; b++) clock_bit(1'b1);
        drv_stop();
        check1("busy_stop_partial", busy, 1'b0);
        for (int p = 0; p < 4; p++) scl_pulse();
        drain("stop_partial");

        // STOP while idle
        drv_stop();
        drain("stop_in_idle");

        // reset mid-byte
        drv_start();
        for (int b = 0; b < 4; b++) clock_bit(1'b1);
        repeat (4) @(negedge clk);
        exp_q.delete();
        reset = 1'b1;
        scl_in = 1'b1; sda_in = 1'b1;
        m_state = 0; m_cnt = 0; m_first = 1'b0;
        repeat (6) @(negedge clk);
        check1("rst_mid_busy", busy, 1'b0);
        check1("rst_mid_first", first_byte, 1'b0);
        reset = 1'b0;
        for (int p = 0; p < 8; p++) scl_pulse();
        drain("reset_mid_byte");
        check1("busy_after_reset_pulses", busy, 1'b0);

        // SDA toggled together with SCL edges
        scl_in = 1'b0; wait_ph();
        for (int p = 0; p < 4; p++) begin
            scl_in = 1'b1; sda_in = 1'b0; wait_ph();
            scl_in = 1'b0; sda_in = 1'b1; wait_ph();
        end
        scl_in = 1'b1; wait_ph();
        drain("sda_with_scl_edge");
        check1("busy_sda_toggle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
